// File: rtl/dram_burst_if.sv
// dram_burst_if: client-side bus of the burst DRAM model (write port, burst read request, read beat stream).
// Revision: 1.0
`default_nettype none

interface dram_burst_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int LEN_WIDTH  = 4
);
    logic                  en_wr;
    logic [ADDR_WIDTH-1:0] addr_wr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] addr_rd;
    logic [LEN_WIDTH-1:0]  rd_len;
    logic                  rd_ready;
    logic                  valid;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_last;

    modport master (
        output en_wr, addr_wr, data_in, rd_req, addr_rd, rd_len,
        input  rd_ready, valid, data_out, rd_last
    );

    modport slave (
        input  en_wr, addr_wr, data_in, rd_req, addr_rd, rd_len,
        output rd_ready, valid, data_out, rd_last
    );
endinterface

`default_nettype wire

// File: rtl/dram_burst.sv
// dram_burst: DRAM model with write-first burst reads and a fixed-latency read pipeline.
// Revision: 1.0
`default_nettype none

module dram_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int RD_LATENCY = 2,
    parameter int LEN_WIDTH  = 4
) (
    input  logic       clk,
    input  logic       srst,
    dram_burst_if.slave bus
);
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic                  rd_ready_q;

    logic                  valid_q [RD_LATENCY];
    logic                  last_q  [RD_LATENCY];
    logic [DATA_WIDTH-1:0] data_q  [RD_LATENCY];

    logic                  w_accept;
    logic                  w_issue;
    logic                  w_issue_last;
    logic [ADDR_WIDTH-1:0] w_issue_addr;
    logic [DATA_WIDTH-1:0] w_issue_data;

    // Beat 0 of a new burst issues straight from the request; later beats come from addr_q.
    always_comb begin
        w_accept     = bus.rd_req && rd_ready_q;
        w_issue      = w_accept || (state_q == S_BURST);
        w_issue_addr = (state_q == S_BURST) ? addr_q : bus.addr_rd;
        w_issue_last = (state_q == S_BURST) ? (rem_q == '0) : (bus.rd_len == '0);
        w_issue_data = (bus.en_wr && (bus.addr_wr == w_issue_addr)) ? bus.data_in
                                                                     : mem[w_issue_addr];
    end

    always_ff @(posedge clk) begin
        if (bus.en_wr) begin
            mem[bus.addr_wr] <= bus.data_in;
        end
    end

    // rem_q counts beats still to issue after the current one.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= S_IDLE;
            rd_ready_q <= 1'b0;
            addr_q     <= '0;
            rem_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rd_ready_q <= 1'b1;
                    if (w_accept) begin
                        addr_q <= bus.addr_rd + ADDR_WIDTH'(1);
                        rem_q  <= bus.rd_len - LEN_WIDTH'(1);
                        if (bus.rd_len != '0) begin
                            state_q    <= S_BURST;
                            rd_ready_q <= 1'b0;
                        end
                    end
                end
                S_BURST: begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                    rem_q  <= rem_q - LEN_WIDTH'(1);
                    if (rem_q == '0) begin
                        state_q    <= S_IDLE;
                        rd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    rd_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Data stages only load on a valid beat so data_out holds between beats.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                valid_q[k] <= 1'b0;
                last_q[k]  <= 1'b0;
                data_q[k]  <= '0;
            end
        end else begin
            valid_q[0] <= w_issue;
            last_q[0]  <= w_issue && w_issue_last;
            if (w_issue) begin
                data_q[0] <= w_issue_data;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                valid_q[k] <= valid_q[k-1];
                last_q[k]  <= last_q[k-1];
                if (valid_q[k-1]) begin
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign bus.rd_ready = rd_ready_q;
    assign bus.valid    = valid_q[RD_LATENCY-1];
    assign bus.rd_last  = last_q[RD_LATENCY-1];
    assign bus.data_out = data_q[RD_LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_dram_burst.sv
// tb_dram_burst: drives three dram_burst instances (latency 1, 2, 5) from one stimulus stream.
// Revision: 1.0
`default_nettype none

module tb_dram_burst;
    localparam int AW   = 18;
    localparam int DW   = 32;
    localparam int LW   = 4;
    localparam int MAXA = (1 << AW) - 1;
    localparam int HMSK = 8191;

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic          en_wr = 1'b0;
    logic [AW-1:0] addr_wr = '0;
    logic [DW-1:0] data_in = '0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] addr_rd = '0;
    logic [LW-1:0] rd_len = '0;

    always #5 clk = ~clk;

    dram_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) if1 ();
    dram_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) if2 ();
    dram_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) if5 ();

    assign if1.en_wr = en_wr;  assign if1.addr_wr = addr_wr;  assign if1.data_in = data_in;
    assign if1.rd_req = rd_req; assign if1.addr_rd = addr_rd; assign if1.rd_len = rd_len;
    assign if2.en_wr = en_wr;  assign if2.addr_wr = addr_wr;  assign if2.data_in = data_in;
    assign if2.rd_req = rd_req; assign if2.addr_rd = addr_rd; assign if2.rd_len = rd_len;
    assign if5.en_wr = en_wr;  assign if5.addr_wr = addr_wr;  assign if5.data_in = data_in;
    assign if5.rd_req = rd_req; assign if5.addr_rd = addr_rd; assign if5.rd_len = rd_len;

    dram_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .LEN_WIDTH(LW))
        u_dut1 (.clk(clk), .srst(srst), .bus(if1.slave));
    dram_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .LEN_WIDTH(LW))
        u_dut2 (.clk(clk), .srst(srst), .bus(if2.slave));
    dram_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(5), .LEN_WIDTH(LW))
        u_dut5 (.clk(clk), .srst(srst), .bus(if5.slave));

    // Reference model: beats waiting to issue, issue history per edge, memory image.
    typedef struct { int addr; bit lst; } beat_t;
    typedef struct { int e; bit lst; logic [DW-1:0] d; } cap_t;
    typedef struct {
        bit req; int addr; int len;
        bit rdy; bit v; bit l; logic [DW-1:0] d;
    } vec_t;

    int            nchk = 0;
    int            nerr = 0;
    int            edge_n = 0;
    int            last_rst = 0;
    bit            m_ready = 1'b0;
    bit            hv [HMSK+1];
    bit            hl [HMSK+1];
    logic [DW-1:0] hd [HMSK+1];
    logic [DW-1:0] mmem [int];
    beat_t         bq [$];
    cap_t          cap2 [$];
    vec_t          tv [9];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", nm, edge_n, act, exp);
        end
    endtask

    task automatic check_dut(input string nm, input int lat, input logic rdy, input logic v,
                             input logic l, input logic [DW-1:0] d);
        int e;
        bit ev;
        e  = edge_n - lat + 1;
        ev = 1'b0;
        if (e >= 1 && e > last_rst) ev = hv[e & HMSK];
        chk({nm, ".rd_ready"}, {31'd0, rdy}, {31'd0, m_ready});
        chk({nm, ".valid"}, {31'd0, v}, {31'd0, ev});
        chk({nm, ".rd_last"}, {31'd0, l}, {31'd0, ev && hl[e & HMSK]});
        if (ev) chk({nm, ".data_out"}, d, hd[e & HMSK]);
    endtask

    task automatic step();
        beat_t b;
        int    idx;
        @(posedge clk);
        edge_n++;
        idx = edge_n & HMSK;
        hv[idx] = 1'b0;
        hl[idx] = 1'b0;
        if (srst) begin
            bq.delete();
            m_ready  = 1'b0;
            last_rst = edge_n;
        end else begin
            if (rd_req && m_ready) begin
                for (int i = 0; i <= int'(rd_len); i++)
                    bq.push_back('{addr: (int'(addr_rd) + i) & MAXA, lst: (i == int'(rd_len))});
            end
            if (bq.size() > 0) begin
                b = bq.pop_front();
                hv[idx] = 1'b1;
                hl[idx] = b.lst;
                hd[idx] = (en_wr && int'(addr_wr) == b.addr) ? data_in : mmem[b.addr];
            end
            m_ready = (bq.size() == 0);
        end
        if (en_wr) mmem[int'(addr_wr)] = data_in;
        #1;
        check_dut("L1", 1, if1.rd_ready, if1.valid, if1.rd_last, if1.data_out);
        check_dut("L2", 2, if2.rd_ready, if2.valid, if2.rd_last, if2.data_out);
        check_dut("L5", 5, if5.rd_ready, if5.valid, if5.rd_last, if5.data_out);
        if (if2.valid) cap2.push_back('{e: edge_n, lst: if2.rd_last, d: if2.data_out});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        en_wr = 1'b1; addr_wr = a[AW-1:0]; data_in = d;
        step();
        en_wr = 1'b0;
    endtask

    task automatic rq(input int a, input int len);
        rd_req = 1'b1; addr_rd = a[AW-1:0]; rd_len = len[LW-1:0];
        step();
        rd_req = 1'b0;
    endtask

    task automatic chk_cap(input string nm, input logic [DW-1:0] exp_d [8], input int n);
        chk({nm, ".beats"}, cap2.size(), n);
        for (int i = 0; i < n && i < cap2.size(); i++) begin
            chk({nm, ".data"}, cap2[i].d, exp_d[i]);
            chk({nm, ".last"}, {31'd0, cap2[i].lst}, {31'd0, (i == n - 1)});
        end
    endtask

    initial begin : main
        logic [DW-1:0] ed [8];
        int            a;

        tv[0] = '{1, 'h10,  0, 1, 0, 0, 32'h0};
        tv[1] = '{0, 0,     0, 1, 1, 1, 32'hDEAD_BEEF};
        tv[2] = '{1, 'h100, 3, 0, 0, 0, 32'h0};
        tv[3] = '{1, 'h300, 0, 0, 1, 0, 32'd1};
        tv[4] = '{0, 0,     0, 0, 1, 0, 32'd2};
        tv[5] = '{0, 0,     0, 1, 1, 0, 32'd3};
        tv[6] = '{0, 0,     0, 1, 1, 1, 32'd4};
        tv[7] = '{0, 0,     0, 1, 0, 0, 32'h0};
        tv[8] = '{0, 0,     0, 1, 0, 0, 32'h0};

        // Reset state
        idle(2);
        chk("reset.data_out", if2.data_out, 32'h0);
        srst = 1'b0;
        step();

        // Directed table: single read then a 4-beat burst with an ignored request
        wr('h10, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) wr('h100 + i, i + 1);
        for (int i = 0; i < 9; i++) begin
            rd_req = tv[i].req; addr_rd = tv[i].addr[AW-1:0]; rd_len = tv[i].len[LW-1:0];
            step();
            chk("tbl.rd_ready", {31'd0, if2.rd_ready}, {31'd0, tv[i].rdy});
            chk("tbl.valid", {31'd0, if2.valid}, {31'd0, tv[i].v});
            chk("tbl.rd_last", {31'd0, if2.rd_last}, {31'd0, tv[i].l});
            if (tv[i].v) chk("tbl.data_out", if2.data_out, tv[i].d);
        end
        rd_req = 1'b0;

        // Back-to-back bursts form a gapless stream
        wr('h200, 32'hA0); wr('h201, 32'hA1); wr('h300, 32'hB0); wr('h301, 32'hB1);
        cap2.delete();
        rq('h200, 1); idle(1); rq('h300, 1); idle(6);
        chk("b2b.beats", cap2.size(), 4);
        ed[0] = 32'hA0; ed[1] = 32'hA1; ed[2] = 32'hB0; ed[3] = 32'hB1;
        for (int i = 0; i < 4 && i < cap2.size(); i++) begin
            chk("b2b.data", cap2[i].d, ed[i]);
            chk("b2b.last", {31'd0, cap2[i].lst}, {31'd0, (i % 2 == 1)});
            chk("b2b.edge", cap2[i].e, cap2[0].e + i);
        end

        // Write/read collision: same-cycle write bypasses, later write does not
        wr('h40, 32'd5);
        cap2.delete();
        en_wr = 1'b1; addr_wr = 'h40; data_in = 32'd9;
        rq('h40, 0);
        wr('h40, 32'd7);
        idle(2); rq('h40, 0); idle(6);
        ed[0] = 32'd9; ed[1] = 32'd7;
        chk("coll.beats", cap2.size(), 2);
        for (int i = 0; i < 2 && i < cap2.size(); i++) chk("coll.data", cap2[i].d, ed[i]);

        // Address wrap
        wr(MAXA - 1, 32'hC1); wr(MAXA, 32'hC2); wr(0, 32'hC3); wr(1, 32'hC4);
        cap2.delete();
        rq(MAXA - 1, 3); idle(8);
        ed[0] = 32'hC1; ed[1] = 32'hC2; ed[2] = 32'hC3; ed[3] = 32'hC4;
        chk_cap("wrap", ed, 4);

        // Reset mid-burst, with a write during reset
        for (int i = 0; i < 8; i++) wr('h500 + i, 32'h5000 + i);
        rq('h500, 7); idle(2);
        srst = 1'b1; en_wr = 1'b1; addr_wr = 'h600; data_in = 32'h66;
        step();
        srst = 1'b0; en_wr = 1'b0;
        chk("rst.rd_ready_held", {31'd0, if2.rd_ready}, 32'd0);
        cap2.delete();
        step();
        chk("rst.rd_ready_after", {31'd0, if2.rd_ready}, 32'd1);
        idle(7);
        chk("rst.no_valid", cap2.size(), 0);
        rq('h500, 7); idle(10);
        for (int i = 0; i < 8; i++) ed[i] = 32'h5000 + i;
        chk_cap("rst.reread", ed, 8);
        cap2.delete();
        rq('h600, 0); idle(6);
        ed[0] = 32'h66;
        chk_cap("rst.write", ed, 1);

        // Randomized traffic on a preloaded address pool
        for (int i = 0; i < 64; i++) wr(i, $urandom);
        for (int i = 0; i < 16; i++) wr(MAXA - i, $urandom);
        for (int n = 0; n < 800; n++) begin
            en_wr   = ($urandom_range(0, 1) == 1);
            a       = ($urandom_range(0, 3) == 0) ? MAXA - int'($urandom_range(0, 15))
                                                  : int'($urandom_range(0, 47));
            addr_wr = a[AW-1:0];
            data_in = $urandom;
            rd_req  = ($urandom_range(0, 2) == 0);
            a       = ($urandom_range(0, 3) == 0) ? MAXA - int'($urandom_range(0, 15))
                                                  : int'($urandom_range(0, 31));
            addr_rd = a[AW-1:0];
            rd_len  = LW'($urandom_range(0, 15));
            srst    = ($urandom_range(0, 99) == 0);
            step();
        end
        en_wr = 1'b0; rd_req = 1'b0; srst = 1'b0;
        idle(10);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dram_burst.md
# dram_burst

Parametrised synthesizable DRAM model for the convolution datapath, replacing the single-word behavioural DRAM. It sits between the DRAM client (conv_layer and its successors) and the backing storage. It adds configurable read latency, multi-word read bursts with a ready/valid handshake, a last-beat flag, and defined write/read collision behaviour. The testbench loads it and dumps results through the same hierarchical access to its storage array.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 18, word address width; depth = 2^ADDR_WIDTH words
- RD_LATENCY, 2, cycles from beat issue to data_out valid; legal range 1..8
- LEN_WIDTH, 4, width of burst length field; maximum burst = 2^LEN_WIDTH words

- clk  in  1  single clock; all logic on its rising edge
- srst  in  1  synchronous, active-high reset
- en_wr  in  1  write strobe; one word per cycle
- addr_wr  in  ADDR_WIDTH  write word address
- data_in  in  DATA_WIDTH  write data
- rd_req  in  1  read burst request
- addr_rd  in  ADDR_WIDTH  burst start address
- rd_len  in  LEN_WIDTH  burst length minus one
- rd_ready  out  1  high when a new burst can be accepted
- valid  out  1  data_out holds a read beat this cycle
- data_out  out  DATA_WIDTH  read data
- rd_last  out  1  high with the final beat of a burst

## Operation
- Storage: array mem[0 .. 2^ADDR_WIDTH-1]. It is not cleared by srst. Contents survive reset.
- Write: when en_wr is high at the edge, mem[addr_wr] <= data_in. Writes are never stalled and are independent of read state.
- Burst accept: rd_req && rd_ready at edge T.
  - Latch the address counter to addr_rd and the remaining count to rd_len.
  - rd_req while rd_ready is low is ignored and not queued.
- Issue: one beat is issued per cycle, beat 0 in cycle T, beat i in cycle T+i, for rd_len+1 beats.
  - The address counter increments by 1 per beat and wraps from 2^ADDR_WIDTH-1 to 0.
- Read-issue semantics:
  - Each beat samples mem at its issue cycle.
  - If en_wr targets the same address in that same cycle, the beat returns data_in (write-first bypass).
  - Writes after the issue cycle are not reflected in that beat.
- Pipeline: a RD_LATENCY-stage shift register carries {valid, last, data}. Beats leave in issue order. There is no backpressure, so the client must accept every beat.
- Controller states:
  - IDLE: rd_ready=1. Moves to BURST on accept with rd_len>0. Stays in IDLE on accept with rd_len=0.
  - BURST: rd_ready=0. Issues the remaining beats and returns to IDLE in the cycle its last beat issues.
- srst: the controller goes to IDLE and all pipeline valid/last bits clear, so any in-flight burst is discarded. A write presented in the same cycle as srst is still performed.

## Timing
- Reset values (cycle after srst high): rd_ready=0 while srst is held, then 1; valid=0; rd_last=0; data_out=0.
- Latency: beat i of a burst accepted at edge T appears with valid=1 in cycle T+i+RD_LATENCY.
- rd_last=1 only with beat rd_len.
- rd_ready goes low at T+1 when rd_len>0 and returns high at T+rd_len+1.
- A new burst accepted at that edge issues its beat 0 immediately, so back-to-back bursts produce a gapless valid stream.
- Throughput: one word per cycle sustained on both read and write simultaneously.
- data_out holds its last value when valid=0. The checker must ignore it then.

## Test plan
- Single read: mem[0x10]=0xDEAD_BEEF, rd_req with addr_rd=0x10, rd_len=0 at T -> valid=1, rd_last=1, data_out=0xDEAD_BEEF at T+2; rd_ready stays 1.
- Burst of 4: mem[0x100..0x103]=1,2,3,4, rd_len=3 at T -> data 1,2,3,4 at T+2..T+5; rd_last only at T+5; rd_ready=0 over T+1..T+3; rd_req at T+1 ignored.
- Back-to-back: burst A (0x200, rd_len=1) at T and burst B (0x300, rd_len=1) at T+2 -> four contiguous valid beats T+2..T+5; rd_last at T+3 and T+5.
- Collision: mem[0x40]=5; en_wr addr 0x40 data 9 in the same cycle as beat issue of 0x40 -> beat returns 9. Write 7 one cycle after issue -> that beat still returns 9, and the next read returns 7.
- Wrap: addr_rd=2^ADDR_WIDTH-2, rd_len=3 -> beats from addresses max-1, max, 0, 1 in order.
- Reset mid-burst: rd_len=7 accepted, srst pulsed at T+3 -> no valid after reset; rd_ready=1 the cycle after srst drops; memory contents unchanged; a new burst reads correctly. Repeat the suite with RD_LATENCY=1 and RD_LATENCY=5.
